// File: rtl/systolic_seq.sv
// Sequencer for one DIM x DIM systolic matrix-multiply pass: clear, feed, drain, read-out.
// Outputs are registered and decoded from the next state/counter, so they line up with the state.
module systolic_seq #(
    parameter int unsigned DIM   = 8,
    parameter int unsigned CNT_W = $clog2(2 * DIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             sa_clr,
    output logic             sa_en,
    output logic             mem_en,
    output logic [CNT_W-1:0] feed_row,
    output logic             feed_zero,
    output logic             c_rd_valid,
    output logic [CNT_W-1:0] c_rd_row,
    input  logic             c_rd_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StRdout,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] FeedLast  = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] DrainLast = CNT_W'(2 * DIM - 3);
    localparam logic [CNT_W-1:0] RowLast   = CNT_W'(DIM - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy_d, done_d, sa_clr_d, sa_en_d, mem_en_d, feed_zero_d, c_rd_valid_d;
    logic [CNT_W-1:0] feed_row_d, c_rd_row_d;

    // Abort wins over every in-pass transition, including the last read-out acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q != StIdle && abort) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        state_d = StClear;
                        cnt_d   = '0;
                    end
                end
                StClear: begin
                    state_d = StFeed;
                    cnt_d   = '0;
                end
                StFeed: begin
                    if (cnt_q == FeedLast) begin
                        state_d = StDrain;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StDrain: begin
                    if (cnt_q == DrainLast) begin
                        state_d = StRdout;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StRdout: begin
                    if (c_rd_ready) begin
                        if (cnt_q == RowLast) begin
                            state_d = StDone;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);
        sa_clr_d     = (state_d == StClear);
        sa_en_d      = (state_d == StFeed) || (state_d == StDrain);
        mem_en_d     = sa_en_d;
        feed_zero_d  = (state_d == StDrain);
        c_rd_valid_d = (state_d == StRdout);
        feed_row_d   = (state_d == StFeed) ? cnt_d : '0;
        c_rd_row_d   = (state_d == StRdout) ? cnt_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sa_clr     <= 1'b0;
            sa_en      <= 1'b0;
            mem_en     <= 1'b0;
            feed_zero  <= 1'b0;
            c_rd_valid <= 1'b0;
            feed_row   <= '0;
            c_rd_row   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy       <= busy_d;
            done       <= done_d;
            sa_clr     <= sa_clr_d;
            sa_en      <= sa_en_d;
            mem_en     <= mem_en_d;
            feed_zero  <= feed_zero_d;
            c_rd_valid <= c_rd_valid_d;
            feed_row   <= feed_row_d;
            c_rd_row   <= c_rd_row_d;
        end
    end

endmodule

// File: tb/tb_systolic_seq.sv
// Self-checking bench for systolic_seq: directed pass scenarios plus randomized traffic
// compared every cycle against a cycle-index reference model.
module tb_systolic_seq;

    localparam int DIM = 8;
    localparam int CW  = $clog2(2 * DIM);

    logic          clk = 1'b0;
    logic          rst, start, abort, c_rd_ready;
    logic          busy, done, sa_clr, sa_en, mem_en, feed_zero, c_rd_valid;
    logic [CW-1:0] feed_row, c_rd_row;

    systolic_seq #(.DIM(DIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .sa_clr    (sa_clr),
        .sa_en     (sa_en),
        .mem_en    (mem_en),
        .feed_row  (feed_row),
        .feed_zero (feed_zero),
        .c_rd_valid(c_rd_valid),
        .c_rd_row  (c_rd_row),
        .c_rd_ready(c_rd_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: a pass is "cycle t since start" plus "rows accepted so far".
    bit m_act;
    int m_t;
    int m_acc;

    int done_cnt, done_cyc, mem_cnt, mem_first, mem_last;
    int rows_acc[DIM];
    bit busy_log[64];
    bit mem_log[64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        m_act = 1'b0;
        m_t   = 0;
        m_acc = 0;
    endfunction

    function automatic void model_edge(input bit st, input bit ab, input bit rd);
        if (m_act) begin
            if (ab) m_act = 1'b0;
            else if (m_t >= 3 * DIM && m_acc < DIM) begin
                if (rd) m_acc++;
                m_t++;
            end else if (m_t >= 3 * DIM) m_act = 1'b0;
            else m_t++;
        end else if (st && !ab) begin
            m_act = 1'b1;
            m_t   = 1;
            m_acc = 0;
        end
    endfunction

    function automatic logic [31:0] model_out();
        logic b, d, cl, se, me, fz, v;
        int   fr, rr;
        {b, d, cl, se, me, fz, v} = '0;
        fr = 0;
        rr = 0;
        if (m_act) begin
            b = 1'b1;
            if (m_t == 1) cl = 1'b1;
            else if (m_t <= DIM + 1) begin
                me = 1'b1; se = 1'b1; fr = m_t - 2;
            end else if (m_t <= 3 * DIM - 1) begin
                me = 1'b1; se = 1'b1; fz = 1'b1;
            end else if (m_acc < DIM) begin
                v = 1'b1; rr = m_acc;
            end else d = 1'b1;
        end
        return 32'({b, d, cl, se, me, fz, v, CW'(fr), CW'(rr)});
    endfunction

    function automatic logic [31:0] dut_vec();
        return 32'({busy, done, sa_clr, sa_en, mem_en, feed_zero, c_rd_valid, feed_row, c_rd_row});
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge(start, abort, c_rd_ready);
        #1;
        check("outputs", dut_vec(), model_out());
    endtask

    // Inputs set after observing cycle k are the inputs for cycle k (sampled at edge k+1).
    task automatic run_pass(input bit bp, input int abort_at, input bit extra, input int rst_at,
                            input int len);
        done_cnt  = 0;
        done_cyc  = -1;
        mem_cnt   = 0;
        mem_first = -1;
        mem_last  = -1;
        for (int i = 0; i < DIM; i++) rows_acc[i] = 0;
        for (int i = 0; i < 64; i++) begin
            busy_log[i] = 1'b0;
            mem_log[i]  = 1'b0;
        end
        start      = 1'b1;
        abort      = (abort_at == 0);
        c_rd_ready = 1'b1;
        for (int k = 1; k <= len; k++) begin
            step();
            busy_log[k] = busy;
            mem_log[k]  = mem_en;
            if (done) begin
                done_cnt++;
                done_cyc = k;
            end
            if (mem_en) begin
                mem_cnt++;
                if (mem_first < 0) mem_first = k;
                mem_last = k;
            end
            if (k == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("async_rst_valid", 32'(c_rd_valid), 32'd0);
                check("async_rst_busy", 32'(busy), 32'd0);
                model_reset();
                #2 rst = 1'b0;
            end
            start      = extra && (k == 5 || k == 20);
            abort      = (k == abort_at);
            c_rd_ready = bp ? (k % 2 == 0) : 1'b1;
            if (c_rd_valid && c_rd_ready) rows_acc[c_rd_row]++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        c_rd_ready = 1'b1;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        check("idle_busy", 32'(busy), 32'd0);

        // Nominal pass
        run_pass(1'b0, -1, 1'b0, -1, 36);
        check("nom_done_cnt", done_cnt, 1);
        check("nom_done_cyc", done_cyc, 32);
        check("nom_busy33", 32'(busy_log[33]), 32'd0);
        check("nom_busy1", 32'(busy_log[1]), 32'd1);
        check("nom_mem_cnt", mem_cnt, 22);
        check("nom_mem_first", mem_first, 2);
        check("nom_mem_last", mem_last, 23);
        for (int i = 0; i < DIM; i++) check($sformatf("nom_row%0d", i), rows_acc[i], 1);

        // Backpressure: ready high on even cycles only
        run_pass(1'b1, -1, 1'b0, -1, 42);
        check("bp_done_cnt", done_cnt, 1);
        check("bp_done_cyc", done_cyc, 39);
        for (int i = 0; i < DIM; i++) check($sformatf("bp_row%0d", i), rows_acc[i], 1);

        // Abort mid-DRAIN, then a clean pass
        run_pass(1'b0, 15, 1'b0, -1, 20);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_busy16", 32'(busy_log[16]), 32'd0);
        check("abort_mem16", 32'(mem_log[16]), 32'd0);
        check("abort_mem15", 32'(mem_log[15]), 32'd1);
        run_pass(1'b0, -1, 1'b0, -1, 36);
        check("post_abort_done_cyc", done_cyc, 32);
        check("post_abort_mem_cnt", mem_cnt, 22);

        // Start while busy is ignored
        run_pass(1'b0, -1, 1'b1, -1, 36);
        check("extra_done_cnt", done_cnt, 1);
        check("extra_done_cyc", done_cyc, 32);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        repeat (3) step();
        check("start_abort_idle", 32'(busy), 32'd0);
        start = 1'b0;
        abort = 1'b0;
        step();

        // Async reset during read-out
        run_pass(1'b0, -1, 1'b0, 27, 36);
        check("rst_done_cnt", done_cnt, 0);
        run_pass(1'b0, -1, 1'b0, -1, 36);
        check("post_rst_done_cyc", done_cyc, 32);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            start      = ($urandom_range(0, 7) == 0);
            abort      = ($urandom_range(0, 60) == 0);
            c_rd_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
